alu_issue_ctrl: RTL and testbench

- Sequential issue controller that sits in front of the 16-bit ALU.
- Accepts 16-bit register-register instruction words over a valid/ready handshake, reads both operands from the register file, and drives the ALU op code and operands.
- Writes the result back to the register file and latches the ALU flags into a processor status register (PSR).
- Produces every Op code the ALU decodes and is the only consumer of its Flags output.

---
 rtl/alu_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue controller for the 16-bit ALU: read both operands, execute,
// write the result back and merge the ALU flags into the PSR.
module alu_issue_ctrl #(
   parameter int NREG   = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_valid,
   input  logic [15:0]       inst_data,
   output logic              inst_ready,
   output logic [ADDR_W-1:0] rf_raddr_a,
   output logic [ADDR_W-1:0] rf_raddr_b,
   input  logic [15:0]       rf_rdata_a,
   input  logic [15:0]       rf_rdata_b,
   output logic [7:0]        alu_op,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   output logic              alu_cin,
   input  logic [15:0]       alu_result,
   input  logic [4:0]        alu_flags,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [15:0]       rf_wdata,
   output logic [4:0]        psr,
   output logic              busy,
   output logic              illegal
);

   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_CMP  = 8'h0B;
   localparam logic [7:0] OP_MOV  = 8'h0D;
   localparam logic [7:0] OP_LSH  = 8'h84;
   localparam logic [7:0] OP_ASHU = 8'h86;

   localparam logic [4:0] FL_C = 5'b00001;
   localparam logic [4:0] FL_L = 5'b00010;
   localparam logic [4:0] FL_F = 5'b00100;
   localparam logic [4:0] FL_Z = 5'b01000;
   localparam logic [4:0] FL_N = 5'b10000;

   if ((1 << ADDR_W) != NREG) begin : g_cfg_check
      $error("alu_issue_ctrl: NREG must equal 2**ADDR_W");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB
   } state_t;

   state_t      r_state;
   logic [7:0]  r_op;

   logic        w_legal;
   logic        w_write;
   logic        w_swap;
   logic        w_bypass;
   logic [4:0]  w_mask;
   logic [15:0] w_result;

   // Decode of the latched {op, opext}; w_swap feeds Rdest as the shifted value.
   always_comb begin
      w_legal  = 1'b1;
      w_write  = 1'b1;
      w_swap   = 1'b0;
      w_bypass = 1'b0;
      w_mask   = '0;
      case (r_op)
         OP_ADD:  w_mask = FL_C | FL_Z | FL_N;
         OP_SUB:  w_mask = FL_Z | FL_N;
         OP_CMP: begin
            w_write = 1'b0;
            w_mask  = FL_L | FL_F | FL_Z | FL_N;
         end
         OP_AND, OP_OR, OP_XOR: w_mask = FL_Z;
         OP_LSH, OP_ASHU: begin
            w_swap = 1'b1;
            w_mask = FL_Z;
         end
         OP_MOV:  w_bypass = 1'b1;
         default: begin
            w_legal = 1'b0;
            w_write = 1'b0;
         end
      endcase
   end

   assign w_result   = w_bypass ? rf_rdata_a : alu_result;
   assign inst_ready = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign alu_cin    = 1'b0;

   always_comb begin
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      if (r_state == S_EXEC) begin
         alu_op = r_op;
         alu_a  = w_swap ? rf_rdata_b : rf_rdata_a;
         alu_b  = w_swap ? rf_rdata_a : rf_rdata_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         rf_raddr_a <= '0;
         rf_raddr_b <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         psr        <= '0;
         illegal    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (inst_valid) begin
                  r_op       <= {inst_data[15:12], inst_data[7:4]};
                  rf_raddr_a <= inst_data[ADDR_W-1:0];
                  rf_raddr_b <= inst_data[8 +: ADDR_W];
                  r_state    <= S_READ;
               end
            end
            S_READ: r_state <= S_EXEC;
            S_EXEC: begin
               // Result, write strobe and masked flag merge are all captured here
               // so WB only presents registered values.
               rf_we    <= w_write;
               rf_waddr <= rf_raddr_b;
               rf_wdata <= w_result;
               illegal  <= ~w_legal;
               psr      <= (psr & ~w_mask) | (alu_flags & w_mask);
               r_state  <= S_WB;
            end
            S_WB: begin
               rf_we   <= 1'b0;
               illegal <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural register file and ALU.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid;
   logic [15:0] inst_data;
   logic        inst_ready;
   logic [3:0]  rf_raddr_a;
   logic [3:0]  rf_raddr_b;
   logic [15:0] rf_rdata_a;
   logic [15:0] rf_rdata_b;
   logic [7:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_cin;
   logic [15:0] alu_result;
   logic [4:0]  alu_flags;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [4:0]  psr;
   logic        busy;
   logic        illegal;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.NREG(16), .ADDR_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .inst_ready (inst_ready),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_rdata_a (rf_rdata_a),
      .rf_rdata_b (rf_rdata_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .psr        (psr),
      .busy       (busy),
      .illegal    (illegal)
   );

   // Register file: synchronous read, write port from the DUT, poke port for setup.
   logic [15:0] regs [16];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;

   always @(posedge clk) begin
      rf_rdata_a <= regs[rf_raddr_a];
      rf_rdata_b <= regs[rf_raddr_b];
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      else if (poke_en) regs[poke_addr] <= poke_data;
   end

   // ALU: unknown codes return 0xDEAD with zero flags; force_flags reports all ones.
   logic        force_flags = 1'b0;
   logic [15:0] m_res;
   logic        m_c, m_l, m_f, m_n, m_known;
   int          m_sh;

   always_comb begin
      m_res   = 16'hDEAD;
      m_c     = 1'b0;
      m_f     = 1'b0;
      m_known = 1'b1;
      m_sh    = int'($signed(alu_b));
      case (alu_op)
         8'h01: m_res = alu_a & alu_b;
         8'h02: m_res = alu_a | alu_b;
         8'h03: m_res = alu_a ^ alu_b;
         8'h05: begin
            m_res = alu_a + alu_b;
            m_c   = ({1'b0, alu_a} + {1'b0, alu_b}) > 17'h0FFFF;
            m_f   = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
         end
         8'h09, 8'h0B: begin
            m_res = alu_b - alu_a;
            m_c   = alu_b < alu_a;
            m_f   = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_b[15]);
         end
         8'h84: m_res = (m_sh < 0) ? (alu_a >> (-m_sh)) : (alu_a << m_sh);
         8'h86: m_res = (m_sh < 0) ? 16'($signed(alu_a) >>> (-m_sh)) : (alu_a << m_sh);
         default: m_known = 1'b0;
      endcase
      m_l = alu_b < alu_a;
      m_n = (alu_op == 8'h0B) ? ($signed(alu_b) < $signed(alu_a)) : m_res[15];
      alu_result = m_res;
      if (force_flags)  alu_flags = '1;
      else if (m_known) alu_flags = {m_n, (m_res == 16'h0000), m_f, m_l, m_c};
      else              alu_flags = '0;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      logic        ill;
      logic [4:0]  psr;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t mk(input string name, input logic we, input logic [3:0] wa,
                               input logic [15:0] wd, input logic ill, input logic [4:0] p);
      exp_t e;
      e.name = name; e.we = we; e.waddr = wa; e.wdata = wd; e.ill = ill; e.psr = p;
      return e;
   endfunction

   // Monitor: accumulates WB pulses and checks them when busy falls.
   int          mon_we_cnt  = 0;
   int          mon_ill_cnt = 0;
   logic [3:0]  mon_wa      = '0;
   logic [15:0] mon_wd      = '0;
   logic        mon_prev    = 1'b0;
   exp_t        mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (rf_we) begin
            mon_we_cnt++;
            mon_wa = rf_waddr;
            mon_wd = rf_wdata;
         end
         if (illegal) mon_ill_cnt++;
         if (mon_prev && !busy) begin
            if (sb.size() == 0) begin
               check("unexpected_retire", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, "_we_pulses"}, mon_we_cnt, {31'd0, mon_e.we});
               if (mon_e.we) begin
                  check({mon_e.name, "_waddr"}, {28'd0, mon_wa}, {28'd0, mon_e.waddr});
                  check({mon_e.name, "_wdata"}, {16'd0, mon_wd}, {16'd0, mon_e.wdata});
               end
               check({mon_e.name, "_illegal_pulses"}, mon_ill_cnt, {31'd0, mon_e.ill});
               check({mon_e.name, "_psr"}, {27'd0, psr}, {27'd0, mon_e.psr});
            end
            mon_we_cnt  = 0;
            mon_ill_cnt = 0;
         end
         mon_prev = busy;
      end
   end

   task automatic poke(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic issue(input logic [15:0] inst, input exp_t e, input bit chk_alu,
                        input logic [7:0] eop, input logic [15:0] ea, input logic [15:0] eb);
      int t;
      t = 0;
      @(negedge clk);
      while (!inst_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({e.name, "_ready_before"}, {31'd0, inst_ready}, 32'd1);
      inst_valid = 1'b1;
      inst_data  = inst;
      sb.push_back(e);
      @(posedge clk); #1;
      inst_valid = 1'b0;
      inst_data  = 16'hF0F0;
      @(negedge clk);
      check({e.name, "_ready_read"}, {31'd0, inst_ready}, 32'd0);
      @(negedge clk);
      check({e.name, "_ready_exec"}, {31'd0, inst_ready}, 32'd0);
      if (chk_alu) begin
         check({e.name, "_alu_op"}, {24'd0, alu_op}, {24'd0, eop});
         check({e.name, "_alu_a"}, {16'd0, alu_a}, {16'd0, ea});
         check({e.name, "_alu_b"}, {16'd0, alu_b}, {16'd0, eb});
      end
      @(negedge clk);
      check({e.name, "_ready_wb"}, {31'd0, inst_ready}, 32'd0);
      @(negedge clk);
      check({e.name, "_ready_after"}, {31'd0, inst_ready}, 32'd1);
   endtask

   initial begin
      int t;
      rst_n      = 1'b0;
      inst_valid = 1'b0;
      inst_data  = '0;
      poke(4'd1, 16'hFFFF);  poke(4'd2, 16'h0001);
      poke(4'd3, 16'h0005);  poke(4'd4, 16'h0007);
      poke(4'd5, 16'h0003);  poke(4'd6, 16'h8000);
      poke(4'd7, 16'h0001);  poke(4'd8, 16'hFFFC);
      poke(4'd9, 16'h1234);  poke(4'd10, 16'h00FF);
      poke(4'd11, 16'h00FF); poke(4'd12, 16'h8000);
      poke(4'd13, 16'hFFFF); poke(4'd0, 16'h5555);
      @(negedge clk);
      check("rst_psr", {27'd0, psr}, 32'd0);
      check("rst_we", {31'd0, rf_we}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, inst_ready}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_alu_op", {24'd0, alu_op}, 32'd0);

      // Data present but valid low: nothing is accepted.
      inst_data = 16'h0251;
      repeat (3) @(negedge clk);
      check("valid_low_busy", {31'd0, busy}, 32'd0);

      // Reset asserted in EXEC abandons the ADD.
      inst_valid = 1'b1;
      sb.push_back(mk("rst_mid", 1'b0, 4'd0, 16'h0, 1'b0, 5'h00));
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(posedge clk); #2;
      check("rst_mid_exec_op", {24'd0, alu_op}, 32'h05);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(16'h0251, mk("add", 1'b1, 4'd2, 16'h0000, 1'b0, 5'h09), 1'b1, 8'h05, 16'hFFFF, 16'h0001);
      issue(16'h0394, mk("sub", 1'b1, 4'd3, 16'hFFFE, 1'b0, 5'h11), 1'b1, 8'h09, 16'h0007, 16'h0005);
      issue(16'h05B6, mk("cmp", 1'b0, 4'd5, 16'h0000, 1'b0, 5'h07), 1'b1, 8'h0B, 16'h8000, 16'h0003);
      issue(16'h8748, mk("lsh_neg", 1'b1, 4'd7, 16'h0000, 1'b0, 5'h0F), 1'b1, 8'h84, 16'h0001, 16'hFFFC);
      poke(4'd7, 16'h0001);
      poke(4'd8, 16'h0004);
      issue(16'h8748, mk("lsh_pos", 1'b1, 4'd7, 16'h0010, 1'b0, 5'h07), 1'b1, 8'h84, 16'h0001, 16'h0004);
      issue(16'h0A3B, mk("xor", 1'b1, 4'd10, 16'h0000, 1'b0, 5'h0F), 1'b0, 8'h00, 16'h0, 16'h0);
      issue(16'h8C6D, mk("ashu", 1'b1, 4'd12, 16'hC000, 1'b0, 5'h07), 1'b1, 8'h86, 16'h8000, 16'hFFFF);
      force_flags = 1'b1;
      issue(16'h05B6, mk("cmp_all", 1'b0, 4'd5, 16'h0000, 1'b0, 5'h1F), 1'b0, 8'h00, 16'h0, 16'h0);
      force_flags = 1'b0;
      issue(16'h01D9, mk("mov", 1'b1, 4'd1, 16'h1234, 1'b0, 5'h1F), 1'b0, 8'h00, 16'h0, 16'h0);
      issue(16'hF000, mk("undef", 1'b0, 4'd0, 16'h0000, 1'b1, 5'h1F), 1'b1, 8'hF0, 16'h5555, 16'h5555);

      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard_drained", sb.size(), 32'd0);
      check("rf_r1_after_mov", {16'd0, regs[1]}, 32'h1234);
      check("rf_r0_untouched", {16'd0, regs[0]}, 32'h5555);
      check("rf_r5_untouched", {16'd0, regs[5]}, 32'h0003);
      check("alu_cin_zero", {31'd0, alu_cin}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
